// File: rtl/elevator_shaft.sv
// elevator_shaft: one cabin in a three-floor shaft with door and floor sensors.
// SHAFT_LEVEL_SENSOR_EN: floor sensors track cabin level instead of pulsing.
module elevator_shaft #(
  parameter int TRAVEL_TICKS = 8,
  parameter int DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ac,
  input  logic       doorOpen,
  output logic       s1,
  output logic       s2,
  output logic       s3,
  output logic [4:0] pos,
  output logic [1:0] cur_floor,
  output logic       door_fb,
  output logic       fault
);

  localparam logic [4:0] MID = 5'(TRAVEL_TICKS);
  localparam logic [4:0] TOP = 5'(2 * TRAVEL_TICKS);
  localparam logic [3:0] DT  = 4'(DOOR_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_OPENING,
    S_OPEN,
    S_CLOSING,
    S_FAULT
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] sens;

  logic [4:0] pos_inc;
  logic [4:0] pos_dec;
  logic [2:0] hit_inc;
  logic [2:0] hit_dec;
  logic [2:0] hit_now;
  logic       at_floor;
  logic       in_door;
  logic       bad;

  function automatic logic [2:0] hit(input logic [4:0] p);
    return {p == TOP, p == MID, p == 5'd0};
  endfunction

  function automatic logic [1:0] floor_of(input logic [2:0] h);
    logic [1:0] f;
    unique case (1'b1)
      h[2]:    f = 2'd3;
      h[1]:    f = 2'd2;
      default: f = 2'd1;
    endcase
    return f;
  endfunction

  assign s1 = sens[0];
  assign s2 = sens[1];
  assign s3 = sens[2];

  // Saturated neighbour positions, floor hits and illegal-command detection
  always_comb begin
    pos_inc  = (pos == TOP) ? pos : pos + 5'd1;
    pos_dec  = (pos == 5'd0) ? pos : pos - 5'd1;
    hit_inc  = hit(pos_inc);
    hit_dec  = hit(pos_dec);
    hit_now  = hit(pos);
    at_floor = |hit_now;
    in_door  = (state == S_OPENING) || (state == S_OPEN) ||
               (state == S_CLOSING);
    bad      = (ac == 2'b11) ||
               (in_door && ac != 2'b00) ||
               (!in_door && ac == 2'b10 && pos == TOP) ||
               (!in_door && ac == 2'b01 && pos == 5'd0);
  end

  // Cabin/door state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pos       <= 5'd0;
      cur_floor <= 2'd1;
      door_fb   <= 1'b0;
      sens      <= 3'b000;
      fault     <= 1'b0;
      cnt       <= 4'd0;
    end else if (state == S_FAULT) begin
      sens <= 3'b000;
    end else if (bad) begin
      state   <= S_FAULT;
      fault   <= 1'b1;
      sens    <= 3'b000;
      door_fb <= 1'b0;
    end else begin
`ifdef SHAFT_LEVEL_SENSOR_EN
      sens <= hit_now;
`else
      sens <= 3'b000;
`endif
      unique case (state)
        S_IDLE: begin
          case (ac)
            2'b10: state <= S_UP;
            2'b01: state <= S_DOWN;
            default: begin
              if (doorOpen && at_floor) begin
                state <= S_OPENING;
                cnt   <= DT;
              end
            end
          endcase
        end
        S_UP, S_DOWN: begin
          case (ac)
            2'b10: begin
              state <= S_UP;
              pos   <= pos_inc;
              sens  <= hit_inc;
              if (|hit_inc) cur_floor <= floor_of(hit_inc);
            end
            2'b01: begin
              state <= S_DOWN;
              pos   <= pos_dec;
              sens  <= hit_dec;
              if (|hit_dec) cur_floor <= floor_of(hit_dec);
            end
            default: state <= S_IDLE;
          endcase
        end
        S_OPENING: begin
          if (!doorOpen) begin
            state <= S_CLOSING;
            cnt   <= DT;
          end else if (cnt <= 4'd1) begin
            state   <= S_OPEN;
            door_fb <= 1'b1;
            cnt     <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_OPEN: begin
          if (!doorOpen) begin
            state   <= S_CLOSING;
            door_fb <= 1'b0;
            cnt     <= DT;
          end
        end
        S_CLOSING: begin
          if (doorOpen) begin
            state <= S_OPENING;
            cnt   <= DT;
          end else if (cnt <= 4'd1) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/elevator_shaft.md
ELEVATOR_SHAFT -- requirements
Module: elevator_shaft

Interface
REQ-001 Parameter TRAVEL_TICKS, default 8, clk cycles of motion between adjacent floors, legal range 2..15.
REQ-002 Parameter DOOR_TICKS, default 3, clk cycles for a full door open or close stroke, legal range 1..15.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 ac  in  2  motor command from the controller: 2'b10 up, 2'b01 down, 2'b00 stop, 2'b11 illegal.
REQ-006 doorOpen  in  1  door command from the controller: 1 open, 0 close.
REQ-007 s1, s2, s3  out  1 each  floor sensors for floors 1..3.
REQ-008 pos  out  5  cabin position in ticks: floor 1 = 0, floor 2 = TRAVEL_TICKS, floor 3 = 2*TRAVEL_TICKS.
REQ-009 cur_floor  out  2  last floor reached or passed, values 1..3.
REQ-010 door_fb  out  1  high only while the door is fully open.
REQ-011 fault  out  1  sticky error flag.

Function
REQ-012 States: IDLE, UP, DOWN, OPENING, OPEN, CLOSING, FAULT; the state register and all outputs are registered.
REQ-013 IDLE with ac=10 and pos<top -> UP; with ac=01 and pos>0 -> DOWN; pos begins changing on the cycle after entry.
REQ-014 UP: pos+1 per cycle while ac=10; DOWN: pos-1 per cycle while ac=01.
REQ-015 UP/DOWN with ac=00 -> IDLE; pos holds, including between floors.
REQ-016 UP with ac=01 -> DOWN, and DOWN with ac=10 -> UP, on the next cycle with no intermediate IDLE cycle.
REQ-017 pos reaching floor n position while moving -> sn high for exactly one cycle, on the same edge that pos updates; cur_floor<=n on that edge; a floor that is passed through still pulses.
REQ-018 IDLE at a floor position with doorOpen=1 -> OPENING; after DOOR_TICKS cycles -> OPEN with door_fb=1.
REQ-019 doorOpen=1 while IDLE between floors is ignored; the state stays IDLE and no fault is raised.
REQ-020 OPEN with doorOpen=0 -> CLOSING; after DOOR_TICKS cycles -> IDLE.
REQ-021 OPENING with doorOpen=0 -> CLOSING with the counter reloaded to DOOR_TICKS; CLOSING with doorOpen=1 -> OPENING, also reloaded.
REQ-022 Any of the following -> FAULT on the next edge:
  - ac=11 in any state;
  - ac!=00 in OPENING, OPEN or CLOSING;
  - ac=10 at pos=top;
  - ac=01 at pos=0.
REQ-023 FAULT: pos frozen, s1..s3=0, door_fb=0, fault=1; exited only by rst.
REQ-024 The door counter and pos never wrap; pos is saturated to the range 0..2*TRAVEL_TICKS.

Reset
REQ-025 rst=1 wins over every other input on the same edge.
REQ-026 rst=1 forces the reset values, including mid-motion or mid-stroke:
  - state=IDLE and pos=0;
  - cur_floor=1 and door_fb=0;
  - s1=s2=s3=0 and fault=0;
  - door counter=0.

Configuration
REQ-027 SHAFT_LEVEL_SENSOR_EN defined: sn is held high for every cycle in which pos equals the floor n position, in any state except FAULT.
REQ-028 SHAFT_LEVEL_SENSOR_EN undefined: sn is a one-cycle pulse per REQ-017 only.

Verification (TRAVEL_TICKS=8, DOOR_TICKS=3)
REQ-029 rst, then ac=10 for 20 cycles -> pos 0..16; s2 pulses at pos=8; s3 pulses at pos=16; cur_floor=3; FAULT at the first ac=10 cycle after pos=16.
REQ-030 At pos=8, ac=00, doorOpen=1 for 6 cycles -> door_fb=1 from the 4th cycle; doorOpen=0 -> door_fb=0 next cycle; IDLE 3 cycles later.
REQ-031 OPEN at floor 1, ac=10 -> fault=1 next cycle; pos stays 0; fault persists until rst.
REQ-032 UP at pos=5, ac=01 -> pos 4 on the cycle after the reversal, then 3, 2, 1, 0; s1 pulses at pos=0; no s2 pulse.
REQ-033 ac=00 at pos=5, doorOpen=1 -> state stays IDLE, door_fb=0, fault=0.
REQ-034 rst asserted at pos=12 while UP -> pos=0, cur_floor=1 and all outputs at reset values next cycle; with SHAFT_LEVEL_SENSOR_EN, s1 is high in the following cycle.
